// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and the receiver lock-state type.
// Shared by the VGA controller and the loopback frame receiver.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_H_SEEN,
        ST_ACQUIRE,
        ST_LOCKED
    } lock_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop sampler for an active-low sync pin with a falling-edge pulse.
// Both flops preset high so leaving reset never looks like a sync edge.
module vga_sync_edge (
    input  logic VGA_clk,
    input  logic reset,
    input  logic sync_pin,
    output logic fall
);

    logic s1;
    logic s2;

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= sync_pin;
            s2 <= s1;
        end
    end

    assign fall = ~s1 & s2;

endmodule

// File: rtl/vga_frame_receiver.sv
// Loopback sink for the VGA pins: recovers pixel position, locks to the
// frame timing and reports per-frame lit-pixel counts and timing errors.
//
// state       | meaning
// UNLOCKED    | waiting for any hsync edge
// H_SEEN      | line timing followed, waiting for first frame boundary
// ACQUIRE     | counting clean frames toward lock
// LOCKED      | timing trusted, statistics accumulating
module vga_frame_receiver #(
    parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP        = vga_timing_pkg::H_FP,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BP        = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP        = vga_timing_pkg::V_FP,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BP        = vga_timing_pkg::V_BP,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 19
) (
    input  logic             VGA_clk,
    input  logic             reset,
    input  logic             VGA_hSync,
    input  logic             VGA_vSync,
    input  logic             blank_n,
    input  logic [7:0]       VGA_R,
    input  logic [7:0]       VGA_G,
    input  logic [7:0]       VGA_B,
    output logic [9:0]       rx_x,
    output logic [9:0]       rx_y,
    output logic             rx_active,
    output logic             locked,
    output logic             frame_done,
    output logic [CNT_W-1:0] r_count,
    output logic [CNT_W-1:0] g_count,
    output logic [CNT_W-1:0] b_count,
    output logic             blank_err,
    output logic [7:0]       err_count
);

    import vga_timing_pkg::*;

    localparam int              HT        = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int              VT        = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]      H_LAST    = 10'(HT - 1);
    localparam logic [9:0]      V_LAST    = 10'(VT - 1);
    localparam logic [9:0]      HS_AT     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]      VS_AT     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]      H_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0]      V_VIS     = 10'(V_ACTIVE);
    localparam logic [7:0]      GOOD_LAST = 8'(LOCK_FRAMES - 1);

    logic h_fall;
    logic v_fall;

    vga_sync_edge u_hsync_edge (
        .VGA_clk  (VGA_clk),
        .reset    (reset),
        .sync_pin (VGA_hSync),
        .fall     (h_fall)
    );

    vga_sync_edge u_vsync_edge (
        .VGA_clk  (VGA_clk),
        .reset    (reset),
        .sync_pin (VGA_vSync),
        .fall     (v_fall)
    );

    // Only the colour MSBs matter for the lit/unlit decision.
    logic unused_colour_bits;
    assign unused_colour_bits = ^{VGA_R[6:0], VGA_G[6:0], VGA_B[6:0]};

    logic blank_s1, r_s1, g_s1, b_s1;
    logic [9:0] hcnt, vcnt;
    logic v_pend;
    lock_state_e state, state_nxt;
    logic [7:0] good, good_nxt;
    logic lose_lock;
    logic [CNT_W-1:0] r_acc, g_acc, b_acc;
    logic blank_acc;

    logic [9:0] fr_h, fr_v, cur_h, cur_v;
    logic h_wrap, boundary, h_err, v_err, in_area, blank_bad;

    // cur_h/cur_v label the sample currently held in the s1 flops.
    always_comb begin
        h_wrap    = (hcnt == H_LAST);
        fr_h      = h_wrap ? 10'd0 : hcnt + 10'd1;
        fr_v      = vcnt;
        if (h_wrap) begin
            fr_v = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end
        boundary  = h_fall && (v_pend || v_fall);
        h_err     = h_fall ? (fr_h != HS_AT) : (fr_h == HS_AT);
        v_err     = boundary && (fr_v != VS_AT);
        cur_h     = h_fall ? HS_AT : fr_h;
        cur_v     = boundary ? VS_AT : fr_v;
        in_area   = (cur_h < H_VIS) && (cur_v < V_VIS);
        blank_bad = (blank_s1 != in_area);
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        lose_lock = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (h_fall) state_nxt = ST_H_SEEN;
            end
            ST_H_SEEN: begin
                if (h_err) begin
                    state_nxt = ST_UNLOCKED;
                end else if (boundary) begin
                    state_nxt = ST_ACQUIRE;
                    good_nxt  = 8'd0;
                end
            end
            ST_ACQUIRE: begin
                if (h_err || v_err) begin
                    state_nxt = ST_UNLOCKED;
                end else if (boundary) begin
                    if (good == GOOD_LAST) state_nxt = ST_LOCKED;
                    else                   good_nxt  = good + 8'd1;
                end
            end
            ST_LOCKED: begin
                if (h_err || v_err) begin
                    state_nxt = ST_UNLOCKED;
                    lose_lock = 1'b1;
                end
            end
            default: state_nxt = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            blank_s1   <= 1'b1;
            r_s1       <= 1'b1;
            g_s1       <= 1'b1;
            b_s1       <= 1'b1;
            hcnt       <= '0;
            vcnt       <= '0;
            v_pend     <= 1'b0;
            state      <= ST_UNLOCKED;
            good       <= '0;
            r_acc      <= '0;
            g_acc      <= '0;
            b_acc      <= '0;
            blank_acc  <= 1'b0;
            r_count    <= '0;
            g_count    <= '0;
            b_count    <= '0;
            blank_err  <= 1'b0;
            frame_done <= 1'b0;
            err_count  <= '0;
        end else begin
            blank_s1   <= blank_n;
            r_s1       <= VGA_R[7];
            g_s1       <= VGA_G[7];
            b_s1       <= VGA_B[7];
            hcnt       <= cur_h;
            vcnt       <= cur_v;
            state      <= state_nxt;
            good       <= good_nxt;
            frame_done <= 1'b0;
            if (boundary)    v_pend <= 1'b0;
            else if (v_fall) v_pend <= 1'b1;
            if (lose_lock && err_count != 8'hFF) err_count <= err_count + 8'd1;

            // A frame that loses lock is dropped; published counts stay put.
            if (state != ST_LOCKED || lose_lock) begin
                r_acc     <= '0;
                g_acc     <= '0;
                b_acc     <= '0;
                blank_acc <= 1'b0;
            end else if (boundary) begin
                r_count    <= r_acc;
                g_count    <= g_acc;
                b_count    <= b_acc;
                blank_err  <= blank_acc;
                frame_done <= 1'b1;
                r_acc      <= CNT_W'(in_area & r_s1);
                g_acc      <= CNT_W'(in_area & g_s1);
                b_acc      <= CNT_W'(in_area & b_s1);
                blank_acc  <= blank_bad;
            end else begin
                r_acc     <= r_acc + CNT_W'(in_area & r_s1);
                g_acc     <= g_acc + CNT_W'(in_area & g_s1);
                b_acc     <= b_acc + CNT_W'(in_area & b_s1);
                blank_acc <= blank_acc | blank_bad;
            end
        end
    end

    assign rx_x      = hcnt;
    assign rx_y      = vcnt;
    assign locked    = (state == ST_LOCKED);
    assign rx_active = locked && (hcnt < H_VIS) && (vcnt < V_VIS);

endmodule
